// File: rtl/nn_pkg.sv
// Shared fixed-point definitions for the network: word type, FSM state codes
// and the saturating clamp used by every neuron.
package nn_pkg;

    localparam int BITS_DEF = 16;
    localparam int FRAC_DEF = 8;

    // Width of the intermediate used by sat(); wide enough for any accumulator here.
    localparam int SAT_W = 64;

    typedef logic signed [BITS_DEF-1:0] fxp_t;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FWD  = 3'd1;
    localparam logic [2:0] ST_BIAS = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;
    localparam logic [2:0] ST_UPD  = 3'd4;
    localparam logic [2:0] ST_BUPD = 3'd5;

    // Clamp a wide signed value into the signed range of a 'bits'-wide word.
    function automatic logic signed [SAT_W-1:0] sat(
        input logic signed [SAT_W-1:0] v,
        input int                      bits
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/nn_fxp_mul.sv
// Signed BITSxBITS multiplier: full-precision product plus the product shifted
// right arithmetically by SHIFT and saturated back to one word.
module nn_fxp_mul
    import nn_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int SHIFT = FRAC_DEF
) (
    input  logic signed [BITS-1:0]   a,
    input  logic signed [BITS-1:0]   b,
    output logic signed [2*BITS-1:0] prod,
    output logic signed [BITS-1:0]   prod_sat
);

    localparam int PW = 2 * BITS;

    assign prod     = PW'(a) * PW'(b);
    assign prod_sat = BITS'(sat(SAT_W'(prod) >>> SHIFT, BITS));

endmodule

// File: rtl/neuron_output.sv
// Linear output neuron: serial MAC forward pass, error/weight export and
// SGD-style weight/bias update on the backward pass, one multiplier shared.
module neuron_output
    import nn_pkg::*;
#(
    parameter int             N        = 3,
    parameter int             BITS     = BITS_DEF,
    parameter int             FRAC     = FRAC_DEF,
    parameter int             LR_SHIFT = 4,
    parameter logic [BITS-1:0] W_INIT  = 16'h0080,
    parameter logic [BITS-1:0] B_INIT  = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            FP,
    input  logic            BP,
    input  logic [BITS-1:0] h [N],
    input  logic [BITS-1:0] y_true,
    output logic [BITS-1:0] y,
    output logic            y_valid,
    output logic [BITS-1:0] dZ,
    output logic            dZ_valid,
    output logic [BITS-1:0] W_out [N],
    output logic            busy,
    output logic            done
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2 * BITS + $clog2(N) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t                  state_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [BITS-1:0]  hcap_reg [N];
    logic signed [BITS-1:0]  w_reg    [N];
    logic signed [BITS-1:0]  w_snap_reg [N];
    logic signed [BITS-1:0]  b_reg;
    logic signed [BITS-1:0]  y_reg;
    logic signed [BITS-1:0]  dz_reg;
    logic                    y_valid_reg;
    logic                    dz_valid_reg;
    logic                    done_reg;
    logic                    fwd_ok_reg;

    logic signed [BITS-1:0]   mul_a;
    logic signed [BITS-1:0]   mul_b;
    logic signed [2*BITS-1:0] mul_prod;
    logic signed [BITS-1:0]   mul_sat;

    logic signed [BITS-1:0]  y_next;
    logic signed [BITS-1:0]  dz_next;
    logic signed [BITS-1:0]  w_next;
    logic signed [BITS-1:0]  b_next;
    logic [N-1:0]            w_sel;
    logic                    idx_last;

    // FWD multiplies weight by captured input; UPD multiplies error by captured input.
    assign mul_a = (state_reg == ST_UPD) ? dz_reg : w_reg[idx_reg];
    assign mul_b = hcap_reg[idx_reg];

    nn_fxp_mul #(
        .BITS  (BITS),
        .SHIFT (FRAC + LR_SHIFT)
    ) u_mul (
        .a        (mul_a),
        .b        (mul_b),
        .prod     (mul_prod),
        .prod_sat (mul_sat)
    );

    assign idx_last = (idx_reg == IDX_LAST);

    always_comb begin
        y_next  = BITS'(sat((SAT_W'(acc_reg) + (SAT_W'(b_reg) <<< FRAC)) >>> FRAC, BITS));
        dz_next = BITS'(sat(SAT_W'(y_reg) - SAT_W'($signed(y_true)), BITS));
        w_next  = BITS'(sat(SAT_W'(w_reg[idx_reg]) - SAT_W'(mul_sat), BITS));
        b_next  = BITS'(sat(SAT_W'(b_reg) - (SAT_W'(dz_reg) >>> LR_SHIFT), BITS));
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sel
            assign w_sel[gi] = (state_reg == ST_UPD) && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            acc_reg      <= '0;
            b_reg        <= B_INIT;
            y_reg        <= '0;
            dz_reg       <= '0;
            y_valid_reg  <= 1'b0;
            dz_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            fwd_ok_reg   <= 1'b0;
        end else begin
            y_valid_reg  <= 1'b0;
            dz_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // FP has priority; a simultaneous BP is simply dropped.
                    if (FP) begin
                        acc_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= ST_FWD;
                    end else if (BP && fwd_ok_reg) begin
                        state_reg <= ST_ERR;
                    end
                end
                ST_FWD: begin
                    acc_reg <= acc_reg + ACC_W'(mul_prod);
                    if (idx_last) begin
                        state_reg <= ST_BIAS;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                ST_BIAS: begin
                    y_reg       <= y_next;
                    y_valid_reg <= 1'b1;
                    fwd_ok_reg  <= 1'b1;
                    state_reg   <= ST_IDLE;
                end
                ST_ERR: begin
                    dz_reg       <= dz_next;
                    dz_valid_reg <= 1'b1;
                    idx_reg      <= '0;
                    state_reg    <= ST_UPD;
                end
                ST_UPD: begin
                    if (idx_last) begin
                        state_reg <= ST_BUPD;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                ST_BUPD: begin
                    b_reg     <= b_next;
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Captured inputs serve both passes, so later changes on h cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                hcap_reg[i] <= '0;
            end
        end else if (state_reg == ST_IDLE && FP) begin
            for (int i = 0; i < N; i++) begin
                hcap_reg[i] <= h[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                w_reg[i] <= W_INIT;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_sel[i]) begin
                    w_reg[i] <= w_next;
                end
            end
        end
    end

    // Snapshot of the pre-update weights for the hidden layer's backward pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                w_snap_reg[i] <= W_INIT;
            end
        end else if (state_reg == ST_ERR) begin
            for (int i = 0; i < N; i++) begin
                w_snap_reg[i] <= w_reg[i];
            end
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_wout
            assign W_out[gi] = w_snap_reg[gi];
        end
    endgenerate

    assign y        = y_reg;
    assign y_valid  = y_valid_reg;
    assign dZ       = dz_reg;
    assign dZ_valid = dz_valid_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;

endmodule

// File: tb/tb_neuron_output.sv
// Directed-vector bench for neuron_output: N=3 default instance plus a
// saturation instance with large initial weights.
module tb_neuron_output;

    logic        clk;
    logic        rst;

    logic        fp;
    logic        bp;
    logic [15:0] h [3];
    logic [15:0] y_true;
    logic [15:0] y;
    logic        y_valid;
    logic [15:0] dz;
    logic        dz_valid;
    logic [15:0] w_out [3];
    logic        busy;
    logic        done;

    logic        s_fp;
    logic        s_bp;
    logic [15:0] s_h [3];
    logic [15:0] s_y_true;
    logic [15:0] s_y;
    logic        s_y_valid;
    logic [15:0] s_dz;
    logic        s_dz_valid;
    logic [15:0] s_w_out [3];
    logic        s_busy;
    logic        s_done;

    int total;
    int bad;

    neuron_output u_dut (
        .clk      (clk),
        .rst      (rst),
        .FP       (fp),
        .BP       (bp),
        .h        (h),
        .y_true   (y_true),
        .y        (y),
        .y_valid  (y_valid),
        .dZ       (dz),
        .dZ_valid (dz_valid),
        .W_out    (w_out),
        .busy     (busy),
        .done     (done)
    );

    neuron_output #(.W_INIT(16'h7F00)) u_sat (
        .clk      (clk),
        .rst      (rst),
        .FP       (s_fp),
        .BP       (s_bp),
        .h        (s_h),
        .y_true   (s_y_true),
        .y        (s_y),
        .y_valid  (s_y_valid),
        .dZ       (s_dz),
        .dZ_valid (s_dz_valid),
        .W_out    (s_w_out),
        .busy     (s_busy),
        .done     (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_h(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        h[0] = a;
        h[1] = b;
        h[2] = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (y !== 16'h0000) begin bad++; $display("FAIL reset_y got=%h exp=0000", y); end
        total++; if (dz !== 16'h0000) begin bad++; $display("FAIL reset_dz got=%h exp=0000", dz); end
        total++; if ({busy, y_valid, dz_valid, done} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, y_valid, dz_valid, done});
        end
        for (int i = 0; i < 3; i++) begin
            total++; if (w_out[i] !== 16'h0080) begin bad++; $display("FAIL reset_wout%0d got=%h exp=0080", i, w_out[i]); end
        end
        $display("reset: y=%h dz=%h busy=%b", y, dz, busy);
    endtask

    task automatic test_bp_without_fp();
        y_true = 16'h0000;
        bp = 1'b1;
        tick();
        bp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if ({busy, dz_valid, done} !== 3'b000) begin
                bad++; $display("FAIL bp_ignored c%0d got=%b exp=000", k, {busy, dz_valid, done});
            end
            tick();
        end
        $display("bp without fp: busy=%b dz_valid=%b", busy, dz_valid);
    endtask

    task automatic test_forward();
        int busy_cycles;
        set_h(16'h0100, 16'h0200, 16'hFF00);
        fp = 1'b1;
        tick();
        fp = 1'b0;
        busy_cycles = 0;
        for (int e = 0; e < 4; e++) begin
            if (e == 1) set_h(16'h1234, 16'h7000, 16'h8000);
            total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL fwd_early_valid e%0d got=%b exp=0", e, y_valid); end
            if (busy === 1'b1) busy_cycles++;
            tick();
        end
        total++; if (busy_cycles != 4) begin bad++; $display("FAIL fwd_busy_cycles got=%0d exp=4", busy_cycles); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fwd_busy_end got=%b exp=0", busy); end
        total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL fwd_valid got=%b exp=1", y_valid); end
        total++; if (y !== 16'h0100) begin bad++; $display("FAIL fwd_y got=%h exp=0100", y); end
        $display("forward: y=%h y_valid=%b busy_cycles=%0d", y, y_valid, busy_cycles);
        tick();
        total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL fwd_valid_pulse got=%b exp=0", y_valid); end
    endtask

    task automatic test_backward();
        y_true = 16'h0080;
        bp = 1'b1;
        tick();
        bp = 1'b0;
        total++; if ({busy, dz_valid} !== 2'b10) begin bad++; $display("FAIL bwd_e0 got=%b exp=10", {busy, dz_valid}); end
        tick();
        total++; if (dz_valid !== 1'b1) begin bad++; $display("FAIL bwd_dz_valid got=%b exp=1", dz_valid); end
        total++; if (dz !== 16'h0080) begin bad++; $display("FAIL bwd_dz got=%h exp=0080", dz); end
        for (int i = 0; i < 3; i++) begin
            total++; if (w_out[i] !== 16'h0080) begin bad++; $display("FAIL bwd_wout%0d got=%h exp=0080", i, w_out[i]); end
        end
        for (int e = 2; e < 5; e++) begin
            tick();
            total++; if ({busy, done, dz_valid} !== 3'b100) begin
                bad++; $display("FAIL bwd_upd e%0d got=%b exp=100", e, {busy, done, dz_valid});
            end
        end
        tick();
        total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL bwd_done got=%b exp=01", {busy, done}); end
        $display("backward: dz=%h done=%b", dz, done);
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL bwd_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_forward_after_update();
        set_h(16'h0100, 16'h0200, 16'hFF00);
        fp = 1'b1;
        tick();
        fp = 1'b0;
        tick();
        tick();
        tick();
        tick();
        total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL fwd2_valid got=%b exp=1", y_valid); end
        total++; if (y !== 16'h00C8) begin bad++; $display("FAIL fwd2_y got=%h exp=00c8", y); end
        for (int i = 0; i < 3; i++) begin
            total++; if (w_out[i] !== 16'h0080) begin bad++; $display("FAIL fwd2_wout_hold%0d got=%h exp=0080", i, w_out[i]); end
        end
        $display("forward after update: y=%h", y);
    endtask

    // BP accepted on the first IDLE edge after y_valid; FP during UPD must be dropped.
    task automatic test_back_to_back();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h0078;
        exp_w[1] = 16'h0070;
        exp_w[2] = 16'h0088;
        y_true = 16'h00C8;
        bp = 1'b1;
        tick();
        bp = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        tick();
        total++; if (dz_valid !== 1'b1) begin bad++; $display("FAIL b2b_dz_valid got=%b exp=1", dz_valid); end
        total++; if (dz !== 16'h0000) begin bad++; $display("FAIL b2b_dz got=%h exp=0000", dz); end
        for (int i = 0; i < 3; i++) begin
            total++; if (w_out[i] !== exp_w[i]) begin bad++; $display("FAIL b2b_wout%0d got=%h exp=%h", i, w_out[i], exp_w[i]); end
        end
        tick();
        fp = 1'b1;
        tick();
        tick();
        fp = 1'b0;
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL fp_in_upd_done got=%b exp=1", done); end
        tick();
        total++; if ({busy, y_valid} !== 2'b00) begin bad++; $display("FAIL fp_in_upd_idle got=%b exp=00", {busy, y_valid}); end
        $display("back to back: dz=%h w_out=%h %h %h", dz, w_out[0], w_out[1], w_out[2]);
    endtask

    task automatic test_fp_bp_together();
        y_true = 16'h0000;
        fp = 1'b1;
        bp = 1'b1;
        tick();
        fp = 1'b0;
        bp = 1'b0;
        tick();
        total++; if (dz_valid !== 1'b0) begin bad++; $display("FAIL both_no_err got=%b exp=0", dz_valid); end
        tick();
        tick();
        tick();
        total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL both_valid got=%b exp=1", y_valid); end
        total++; if (y !== 16'h00C8) begin bad++; $display("FAIL both_y got=%h exp=00c8", y); end
        tick();
        total++; if ({busy, dz_valid} !== 2'b00) begin bad++; $display("FAIL both_bp_dropped got=%b exp=00", {busy, dz_valid}); end
        $display("fp+bp together: y=%h busy=%b", y, busy);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) s_h[i] = 16'h7F00;
        s_fp = 1'b1;
        tick();
        s_fp = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        total++; if (s_y_valid !== 1'b1) begin bad++; $display("FAIL sat_valid got=%b exp=1", s_y_valid); end
        total++; if (s_y !== 16'h7FFF) begin bad++; $display("FAIL sat_y got=%h exp=7fff", s_y); end
        s_y_true = 16'h8000;
        s_bp = 1'b1;
        tick();
        s_bp = 1'b0;
        tick();
        total++; if (s_dz_valid !== 1'b1) begin bad++; $display("FAIL sat_dz_valid got=%b exp=1", s_dz_valid); end
        total++; if (s_dz !== 16'h7FFF) begin bad++; $display("FAIL sat_dz got=%h exp=7fff", s_dz); end
        total++; if (s_w_out[1] !== 16'h7F00) begin bad++; $display("FAIL sat_wout got=%h exp=7f00", s_w_out[1]); end
        for (int e = 2; e <= 5; e++) tick();
        total++; if (s_done !== 1'b1) begin bad++; $display("FAIL sat_done got=%b exp=1", s_done); end
        tick();
        $display("saturation: y=%h dz=%h", s_y, s_dz);
    endtask

    task automatic test_reset_mid_pass();
        set_h(16'h0100, 16'h0200, 16'hFF00);
        fp = 1'b1;
        tick();
        fp = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (y !== 16'h0000) begin bad++; $display("FAIL midrst_y got=%h exp=0000", y); end
        for (int i = 0; i < 3; i++) begin
            total++; if (w_out[i] !== 16'h0080) begin bad++; $display("FAIL midrst_wout%0d got=%h exp=0080", i, w_out[i]); end
        end
        tick();
        rst = 1'b0;
        tick();
        y_true = 16'h0000;
        bp = 1'b1;
        tick();
        bp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if ({busy, dz_valid} !== 2'b00) begin bad++; $display("FAIL midrst_bp c%0d got=%b exp=00", k, {busy, dz_valid}); end
            tick();
        end
        fp = 1'b1;
        tick();
        fp = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL midrst_fwd_valid got=%b exp=1", y_valid); end
        total++; if (y !== 16'h0100) begin bad++; $display("FAIL midrst_fwd_y got=%h exp=0100", y); end
        $display("reset mid-pass: y after reforward=%h", y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        fp = 1'b0;
        bp = 1'b0;
        y_true = 16'h0000;
        set_h(16'h0000, 16'h0000, 16'h0000);
        s_fp = 1'b0;
        s_bp = 1'b0;
        s_y_true = 16'h0000;
        for (int i = 0; i < 3; i++) s_h[i] = 16'h0000;
        #2;

        test_reset();
        test_bp_without_fp();
        test_forward();
        test_backward();
        test_forward_after_update();
        test_back_to_back();
        test_fp_bp_together();
        test_saturation();
        test_reset_mid_pass();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_output.md
# neuron_output

Linear output neuron for the fixed-point (8.8, two's-complement) network. It sits directly downstream of the hidden `Neuron_ReLU` layer.

- **Forward pass:** consumes the N hidden activations and produces the network output `y`. It uses one serial multiply-accumulate per cycle.
- **Backward pass:** computes the output error `dZ = y - y_true`. It presents `dZ` and the pre-update weights to the hidden neurons (their `dZ_in`/`W_in`), then updates its own weights and bias.
- **Sequencing:** driven by the `FPO`/`BPO` pulses from `ArchCTRL`.

## Interface
Parameters:
- `N`, 3: number of hidden inputs (≥1).
- `BITS`, 16: word width.
- `FRAC`, 8: fractional bits.
- `LR_SHIFT`, 4: learning rate as 2^-LR_SHIFT.
- `W_INIT`, 16'h0080: reset value of every weight.
- `B_INIT`, 16'h0000: reset value of the bias.

Ports (asynchronous active-high reset `rst`, single clock `clk`):
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `FP`  in  1  forward-pass start pulse (`ArchCTRL` `FPO`).
- `BP`  in  1  backward-pass start pulse (`ArchCTRL` `BPO`).
- `h`  in  [N][BITS]  hidden activations (hidden `y` outputs).
- `y_true`  in  BITS  target value.
- `y`  out  BITS  network output.
- `y_valid`  out  1  one-cycle pulse when `y` updates.
- `dZ`  out  BITS  output error, to hidden `dZ_in`.
- `dZ_valid`  out  1  one-cycle pulse when `dZ` and `W_out` update.
- `W_out`  out  [N][BITS]  weight snapshot, to hidden `W_in`.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle pulse at end of the backward pass.

## Operation
- **States:** IDLE, FWD, BIAS, ERR, UPD, BUPD. A counter `idx` runs 0..N-1 in FWD and UPD.
- **IDLE + FP:**
  - Capture `h` into `hcap`.
  - Clear the accumulator (width 2·BITS+clog2(N)+1).
  - Set `idx`=0 and go to FWD.
- **FWD:** `acc += hcap[idx]*w[idx]` (signed full product). After `idx`=N-1, go to BIAS.
- **BIAS:**
  - `y = sat((acc + (b<<FRAC)) >>> FRAC)`.
  - Pulse `y_valid`, set `fwd_ok`, return to IDLE.
  - No activation function is applied.
- **IDLE + BP:**
  - If `fwd_ok`=0, BP is ignored.
  - Otherwise go to ERR.
- **ERR:**
  - `dZ = sat(y - y_true)` and `W_out = w`; pulse `dZ_valid`.
  - Go to UPD, `idx`=0.
- **UPD:** `w[idx] = sat(w[idx] - sat((dZ*hcap[idx]) >>> (FRAC+LR_SHIFT)))`. After N-1, go to BUPD.
- **BUPD:** `b = sat(b - (dZ >>> LR_SHIFT))`; pulse `done`; return to IDLE.
- **Saturation:** every `sat` clamps to 16'h7FFF / 16'h8000. Arithmetic shifts truncate toward −∞.
- **FP and BP both high in IDLE:** FP wins; BP is dropped.
- **FP/BP while busy:** ignored.
- **`h` changes after capture:** no effect on the pass in progress; `hcap` is used for both passes.
- **`W_out` stability:** changes only in ERR and holds the pre-update weights until the next ERR.

## Timing
- Edge 0 samples the start pulse.
- **Forward pass:**
  - FWD at edges 1..N.
  - BIAS at edge N+1: `y` updates and `y_valid` is high for the cycle after edge N+1.
  - Forward latency is N+1 cycles.
- **Backward pass:**
  - ERR at edge 1: `dZ`, `W_out`, `dZ_valid`.
  - UPD at edges 2..N+1.
  - BUPD at edge N+2: `done`.
- **`busy`:** high from edge 1 until the edge that returns to IDLE.
- **Back-to-back passes:** a new pulse is accepted on the first edge with state=IDLE.
- **Reset values** (asynchronous, any time, including mid-pass):
  - Outputs: `y`=0, `dZ`=0, `W_out`=all `W_INIT`, `y_valid`/`dZ_valid`/`done`/`busy`=0.
  - Internal: state=IDLE, weights=`W_INIT`, `b`=`B_INIT`, `fwd_ok`=0, accumulator=0.

## Structure
- **Package `nn_pkg`:**
  - `BITS`/`FRAC` defaults.
  - The fixed-point word typedef.
  - The state enum.
  - The `sat` function, shared with `Neuron_ReLU`.
- **Sub-module `nn_fxp_mul`:** signed BITS×BITS multiply returning the full product plus the shifted, saturated result. It is instantiated once and time-shared by FWD and UPD.

## Test plan
All scenarios use N=3 and default parameters unless stated.

- **Forward:** `h`={0x0100, 0x0200, 0xFF00}, FP → `y`=0x0100, `y_valid` pulse after edge 4, `busy` for 4 cycles.
- **Backward:** then `y_true`=0x0080, BP →
  - After edge 1: `dZ`=0x0080, `W_out`={0x0080 ×3}.
  - After edge 5: `w`={0x0078, 0x0070, 0x0088}, `b`=0xFFF8, `done` pulse.
- **Forward after update:** same `h`, FP → `y`=0x00C8.
- **Saturation:** `W_INIT`=0x7F00, `h`={0x7F00 ×3}, FP → `y`=0x7FFF. BP with `y_true`=0x8000 → `dZ`=0x7FFF.
- **Ignored pulses:**
  - BP after reset with no prior FP → no state change, `busy`=0.
  - FP and BP high together in IDLE → forward pass only.
  - FP during UPD → ignored.
- **Reset mid-pass:** `rst` asserted during FWD at edge 2 → immediately `busy`=0, `y`=0, weights=`W_INIT`. A later BP is ignored because `fwd_ok`=0.
